// File: rtl/iob_fifo_sync_fwft_pkg.sv
// -----------------------------------------------------------------------------
// iob_fifo_sync_fwft_pkg
//  Shared definitions for the synchronous FIFO slice: depth / level-width
//  helpers, read-mode constants, the prefetch buffer depth and the sticky
//  error flag record.
// -----------------------------------------------------------------------------
package iob_fifo_sync_fwft_pkg;

   // Read-mode selector values for the FWFT parameter.
   localparam int FWFT_STD = 0;   // data one cycle after r_en_i
   localparam int FWFT_ON  = 1;   // head word presented before r_en_i

   // Number of words held by the first-word-fall-through prefetch stage.
   localparam int PF_DEPTH = 2;

   // Number of words addressable by an ADDR_W-bit RAM address.
   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

   // A level counter must represent 0..DEPTH inclusive.
   function automatic int level_w(input int addr_w);
      return addr_w + 1;
   endfunction

   // Sticky error flags, cleared only by reset or err_clr_i.
   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

endpackage : iob_fifo_sync_fwft_pkg

// File: rtl/iob_fifo_sync_fwft_if.sv
// -----------------------------------------------------------------------------
// iob_fifo_sync_fwft_if
//  Bundles every FIFO signal except clock and reset.
//   Control : flush_i, err_clr_i
//   Write   : w_en_i, w_data_i, w_full_o, almost_full_o
//   Read    : r_en_i, r_data_o, r_empty_o, almost_empty_o
//   Status  : level_o, overflow_o, underflow_o
//   RAM     : ext_mem_* (2-port RAM with 1-cycle registered read)
//  slave  = the FIFO itself; master = producer/consumer/RAM environment.
// -----------------------------------------------------------------------------
interface iob_fifo_sync_fwft_if
   import iob_fifo_sync_fwft_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);

   logic                       flush_i;
   logic                       err_clr_i;

   logic                       w_en_i;
   logic [DATA_W-1:0]          w_data_i;
   logic                       w_full_o;
   logic                       almost_full_o;

   logic                       r_en_i;
   logic [DATA_W-1:0]          r_data_o;
   logic                       r_empty_o;
   logic                       almost_empty_o;

   logic [level_w(ADDR_W)-1:0] level_o;
   logic                       overflow_o;
   logic                       underflow_o;

   logic                       ext_mem_clk_o;
   logic                       ext_mem_w_en_o;
   logic [ADDR_W-1:0]          ext_mem_w_addr_o;
   logic [DATA_W-1:0]          ext_mem_w_data_o;
   logic                       ext_mem_r_en_o;
   logic [ADDR_W-1:0]          ext_mem_r_addr_o;
   logic [DATA_W-1:0]          ext_mem_r_data_i;

   modport slave (
      input  flush_i, err_clr_i,
      input  w_en_i, w_data_i,
      output w_full_o, almost_full_o,
      input  r_en_i,
      output r_data_o, r_empty_o, almost_empty_o,
      output level_o, overflow_o, underflow_o,
      output ext_mem_clk_o, ext_mem_w_en_o, ext_mem_w_addr_o, ext_mem_w_data_o,
      output ext_mem_r_en_o, ext_mem_r_addr_o,
      input  ext_mem_r_data_i
   );

   modport master (
      output flush_i, err_clr_i,
      output w_en_i, w_data_i,
      input  w_full_o, almost_full_o,
      output r_en_i,
      input  r_data_o, r_empty_o, almost_empty_o,
      input  level_o, overflow_o, underflow_o,
      input  ext_mem_clk_o, ext_mem_w_en_o, ext_mem_w_addr_o, ext_mem_w_data_o,
      input  ext_mem_r_en_o, ext_mem_r_addr_o,
      output ext_mem_r_data_i
   );

endinterface : iob_fifo_sync_fwft_if

// File: rtl/iob_fifo_sync_fwft_prefetch.sv
// -----------------------------------------------------------------------------
// iob_fifo_sync_fwft_prefetch
//  Two-entry prefetch stage for first-word-fall-through reads. It keeps the
//  RAM read pipeline busy so the head word is always presented, and sustains
//  one word per cycle while pop_i is held.
//  Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   flush_i         drop buffered and in-flight words
//   level_i         words held by the whole FIFO (RAM + in-flight + buffer)
//   pop_i           effective read of the presented word (already qualified)
//   mem_r_data_i    RAM read data, valid the cycle after mem_r_en_o
//   mem_r_en_o      RAM read request (caller advances its read pointer)
//   data_o          presented head word
//   empty_o         no word presented
// -----------------------------------------------------------------------------
module iob_fifo_sync_fwft_prefetch
   import iob_fifo_sync_fwft_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LVL_W  = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [LVL_W-1:0]  level_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] mem_r_data_i,
   output logic              mem_r_en_o,
   output logic [DATA_W-1:0] data_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] slot0, slot1;          // slot0 is the head
   logic [DATA_W-1:0] slot0_nxt, slot1_nxt;
   logic [1:0]        cnt, cnt_nxt;          // words parked in the slots
   logic              rd_vld;                // RAM data lands this cycle
   logic [LVL_W-1:0]  held;
   logic [2:0]        keep;
   logic              ram_avail;

   // Words already owned by this stage; anything beyond that in level_i is
   // still sitting unread in the RAM.
   assign held      = LVL_W'(cnt) + LVL_W'(rd_vld);
   assign ram_avail = (level_i > held);

   // Occupancy after this edge if no further read were issued. A new read is
   // only launched when its word is guaranteed a slot on arrival; counting
   // the pop this cycle is what allows back-to-back delivery.
   assign keep       = {1'b0, cnt} + {2'b00, rd_vld} - {2'b00, pop_i};
   assign mem_r_en_o = ~rst_i & ~flush_i & ram_avail & (keep < 3'(PF_DEPTH));

   // An arriving word is presented straight from the RAM output while the
   // slots are empty, which gives the two-cycle write-to-visible latency.
   assign empty_o = (cnt == 2'd0) & ~rd_vld;
   assign data_o  = ((cnt == 2'd0) && rd_vld) ? mem_r_data_i : slot0;

   // NOTE: every signal written here gets a default first so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      slot0_nxt = slot0;
      slot1_nxt = slot1;
      cnt_nxt   = cnt;
      if (pop_i && (cnt != 2'd0)) begin
         slot0_nxt = slot1;
         cnt_nxt   = cnt - 2'd1;
      end
      // An arriving word popped while the slots are empty bypasses them.
      if (rd_vld && !(pop_i && (cnt == 2'd0))) begin
         if (cnt_nxt == 2'd0) begin
            slot0_nxt = mem_r_data_i;
         end else begin
            slot1_nxt = mem_r_data_i;
         end
         cnt_nxt = cnt_nxt + 2'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the slots are data storage but are reset anyway because
         // slot0 drives r_data_o, which must read as zero after reset.
         slot0  <= '0;
         slot1  <= '0;
         cnt    <= 2'd0;
         rd_vld <= 1'b0;
      end else if (flush_i) begin
         // Stale slot contents are unreachable once cnt is zero; a read
         // still in flight is discarded by clearing rd_vld.
         cnt    <= 2'd0;
         rd_vld <= 1'b0;
      end else begin
         slot0  <= slot0_nxt;
         slot1  <= slot1_nxt;
         cnt    <= cnt_nxt;
         rd_vld <= mem_r_en_o;
      end
   end

endmodule : iob_fifo_sync_fwft_prefetch

// File: rtl/iob_fifo_sync_fwft.sv
// -----------------------------------------------------------------------------
// iob_fifo_sync_fwft
//  Single-clock FIFO on an external 2-port RAM (1-cycle registered read) with
//  optional first-word-fall-through, almost-full/almost-empty thresholds,
//  flush and sticky overflow/underflow flags.
//  Ports:
//   clk_i  clock (also forwarded as ext_mem_clk_o)
//   rst_i  synchronous reset, active-high
//   bus    iob_fifo_sync_fwft_if.slave: write/read handshakes, status flags,
//          level, sticky errors and the external RAM port
//  Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), FWFT (0 std / 1 FWFT),
//   AFULL_TH (almost_full when level >= AFULL_TH),
//   AEMPTY_TH (almost_empty when level <= AEMPTY_TH).
// -----------------------------------------------------------------------------
module iob_fifo_sync_fwft
   import iob_fifo_sync_fwft_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int FWFT      = FWFT_STD,
   parameter int AFULL_TH  = (2 ** ADDR_W) - 1,
   parameter int AEMPTY_TH = 1
) (
   input logic                 clk_i,
   input logic                 rst_i,
   iob_fifo_sync_fwft_if.slave bus
);

   localparam int               DEPTH    = fifo_depth(ADDR_W);
   localparam int               LVL_W    = level_w(ADDR_W);
   localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_TH);
   localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_TH);

   logic [ADDR_W-1:0] w_ptr, r_ptr;
   logic [LVL_W-1:0]  level, level_nxt;
   logic              w_full, r_empty;
   logic              almost_full, almost_empty;
   err_flags_t        err;
   logic              wr_eff, rd_eff, mem_r_en;
   logic [DATA_W-1:0] r_data;

   // Flush and reset override both requests. w_full is the registered flag,
   // so a write while full is dropped even if a read frees a slot this cycle.
   assign wr_eff = bus.w_en_i & ~w_full  & ~bus.flush_i & ~rst_i;
   assign rd_eff = bus.r_en_i & ~r_empty & ~bus.flush_i & ~rst_i;

   always_comb begin
      level_nxt = level;
      if (bus.flush_i) begin
         level_nxt = '0;
      end else begin
         case ({wr_eff, rd_eff})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_ptr        <= '0;
         r_ptr        <= '0;
         level        <= '0;
         w_full       <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         err          <= '0;
      end else begin
         if (bus.flush_i) begin
            w_ptr <= '0;
            r_ptr <= '0;
         end else begin
            if (wr_eff)   w_ptr <= w_ptr + 1'b1;
            if (mem_r_en) r_ptr <= r_ptr + 1'b1;
         end
         level        <= level_nxt;
         w_full       <= (level_nxt == DEPTH_L);
         almost_full  <= (level_nxt >= AFULL_L);
         almost_empty <= (level_nxt <= AEMPTY_L);
         // A new error event wins over a clear in the same cycle.
         err.overflow  <= (bus.w_en_i & w_full  & ~bus.flush_i)
                        | (err.overflow  & ~bus.err_clr_i);
         err.underflow <= (bus.r_en_i & r_empty & ~bus.flush_i)
                        | (err.underflow & ~bus.err_clr_i);
      end
   end

   if (FWFT == FWFT_ON) begin : g_fwft
      iob_fifo_sync_fwft_prefetch #(
         .DATA_W (DATA_W),
         .LVL_W  (LVL_W)
      ) u_prefetch (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .flush_i      (bus.flush_i),
         .level_i      (level),
         .pop_i        (rd_eff),
         .mem_r_data_i (bus.ext_mem_r_data_i),
         .mem_r_en_o   (mem_r_en),
         .data_o       (r_data),
         .empty_o      (r_empty)
      );
   end else begin : g_std
      logic              rd_pending;   // RAM output carries a fresh word
      logic [DATA_W-1:0] hold;
      logic              empty_q;

      assign mem_r_en = rd_eff;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rd_pending <= 1'b0;
            hold       <= '0;
            empty_q    <= 1'b1;
         end else begin
            rd_pending <= rd_eff;
            if (rd_pending) hold <= bus.ext_mem_r_data_i;
            empty_q    <= (level_nxt == '0);
         end
      end

      // The last word read stays on r_data_o until the next read, even if
      // the RAM output register changes underneath.
      assign r_data  = rd_pending ? bus.ext_mem_r_data_i : hold;
      assign r_empty = empty_q;
   end

   assign bus.w_full_o         = w_full;
   assign bus.almost_full_o    = almost_full;
   assign bus.r_data_o         = r_data;
   assign bus.r_empty_o        = r_empty;
   assign bus.almost_empty_o   = almost_empty;
   assign bus.level_o          = level;
   assign bus.overflow_o       = err.overflow;
   assign bus.underflow_o      = err.underflow;

   assign bus.ext_mem_clk_o    = clk_i;
   assign bus.ext_mem_w_en_o   = wr_eff;
   assign bus.ext_mem_w_addr_o = w_ptr;
   assign bus.ext_mem_w_data_o = bus.w_data_i;
   assign bus.ext_mem_r_en_o   = mem_r_en;
   assign bus.ext_mem_r_addr_o = r_ptr;

endmodule : iob_fifo_sync_fwft

// File: tb/tb_iob_fifo_sync_fwft.sv
// -----------------------------------------------------------------------------
// tb_iob_fifo_sync_fwft
//  Drives a standard-read FIFO (dut0) and an FWFT FIFO (dut1) with identical
//  stimulus. Each has its own external RAM model. Expected values come from a
//  queue of (data, write cycle): a word is readable once
//  cycle - write_cycle >= LAT (1 for standard, 2 for FWFT).
// -----------------------------------------------------------------------------
module tb_iob_fifo_sync_fwft;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   iob_fifo_sync_fwft_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   iob_fifo_sync_fwft_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   iob_fifo_sync_fwft #(
      .DATA_W(DW), .ADDR_W(AW), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)
   ) dut0 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus0)
   );

   iob_fifo_sync_fwft #(
      .DATA_W(DW), .ADDR_W(AW), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)
   ) dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus1)
   );

   // External RAMs: synchronous write, registered read.
   logic [DW-1:0] ram0 [DEPTH];
   logic [DW-1:0] ram1 [DEPTH];

   always @(posedge clk) begin
      if (bus0.ext_mem_w_en_o) ram0[bus0.ext_mem_w_addr_o] <= bus0.ext_mem_w_data_o;
      if (bus0.ext_mem_r_en_o) bus0.ext_mem_r_data_i <= ram0[bus0.ext_mem_r_addr_o];
      if (bus1.ext_mem_w_en_o) ram1[bus1.ext_mem_w_addr_o] <= bus1.ext_mem_w_data_o;
      if (bus1.ext_mem_r_en_o) bus1.ext_mem_r_data_i <= ram1[bus1.ext_mem_r_addr_o];
   end

   // Reference model
   typedef struct {
      logic [DW-1:0] d;
      int            wc;
   } ent_t;

   ent_t          mq [2][$];
   logic          ov_m   [2];
   logic          un_m   [2];
   logic [DW-1:0] last_m [2];
   int            lat    [2] = '{1, 2};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input int idx,
                      input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d cyc=%0d: got 0x%0h want 0x%0h", tag, idx, cyc, obs, exp);
      end
   endtask

   function automatic logic exp_empty(input int i);
      return !((mq[i].size() > 0) && (mq[i][0].wc <= cyc - lat[i]));
   endfunction

   task automatic check_dut(input int i, input logic [2:0] lvl, input logic wf,
                            input logic re, input logic af, input logic ae,
                            input logic ov, input logic un, input logic [DW-1:0] rd);
      int sz;
      sz = mq[i].size();
      chk("level",        i, 32'(lvl), 32'(sz));
      chk("w_full",       i, 32'(wf),  32'(sz == DEPTH));
      chk("r_empty",      i, 32'(re),  32'(exp_empty(i)));
      chk("almost_full",  i, 32'(af),  32'(sz >= 3));
      chk("almost_empty", i, 32'(ae),  32'(sz <= 1));
      chk("overflow",     i, 32'(ov),  32'(ov_m[i]));
      chk("underflow",    i, 32'(un),  32'(un_m[i]));
      if (i == 0) begin
         chk("r_data", i, 32'(rd), 32'(last_m[0]));
      end else if (!exp_empty(1)) begin
         chk("r_data", i, 32'(rd), 32'(mq[1][0].d));
      end
   endtask

   task automatic check_all();
      check_dut(0, bus0.level_o, bus0.w_full_o, bus0.r_empty_o, bus0.almost_full_o,
                bus0.almost_empty_o, bus0.overflow_o, bus0.underflow_o, bus0.r_data_o);
      check_dut(1, bus1.level_o, bus1.w_full_o, bus1.r_empty_o, bus1.almost_full_o,
                bus1.almost_empty_o, bus1.overflow_o, bus1.underflow_o, bus1.r_data_o);
   endtask

   // One clock cycle: drive inputs, advance the model, clock, check outputs.
   task automatic step(input logic r_st, input logic w, input logic [DW-1:0] wd,
                       input logic r, input logic fl, input logic clr);
      rst = r_st;
      bus0.w_en_i = w;  bus0.w_data_i = wd; bus0.r_en_i = r;
      bus0.flush_i = fl; bus0.err_clr_i = clr;
      bus1.w_en_i = w;  bus1.w_data_i = wd; bus1.r_en_i = r;
      bus1.flush_i = fl; bus1.err_clr_i = clr;
      for (int i = 0; i < 2; i++) begin
         logic full, empty;
         ent_t e;
         full  = (mq[i].size() == DEPTH);
         empty = exp_empty(i);
         if (r_st) begin
            mq[i].delete();
            ov_m[i]   = 1'b0;
            un_m[i]   = 1'b0;
            last_m[i] = '0;
         end else begin
            if (fl) begin
               mq[i].delete();
            end else begin
               if (r && !empty) begin
                  last_m[i] = mq[i][0].d;
                  void'(mq[i].pop_front());
               end
               if (w && !full) begin
                  e.d  = wd;
                  e.wc = cyc;
                  mq[i].push_back(e);
               end
            end
            ov_m[i] = (!fl && w && full)  || (ov_m[i] && !clr);
            un_m[i] = (!fl && r && empty) || (un_m[i] && !clr);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic wr(input logic [DW-1:0] d);
      step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd();
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         ram0[a] = '0;
         ram1[a] = '0;
      end
      for (int i = 0; i < 2; i++) begin
         ov_m[i] = 1'b0; un_m[i] = 1'b0; last_m[i] = '0;
      end

      // Reset
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
      chk("rst_r_data", 0, 32'(bus0.r_data_o), 32'h0);
      chk("rst_r_data", 1, 32'(bus1.r_data_o), 32'h0);
      chk("rst_r_empty", 1, 32'(bus1.r_empty_o), 32'h1);

      // Fill to full, fifth write dropped
      wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
      chk("full_after_4", 0, 32'(bus0.w_full_o), 32'h1);
      chk("full_after_4", 1, 32'(bus1.w_full_o), 32'h1);
      wr(8'h55);
      chk("ovf_5th", 0, 32'(bus0.overflow_o), 32'h1);
      chk("ovf_5th", 1, 32'(bus1.overflow_o), 32'h1);
      chk("lvl_5th", 0, 32'(bus0.level_o), 32'h4);

      // Drain in order, then one read too many
      idle(); idle();
      rd();
      chk("first_rd", 0, 32'(bus0.r_data_o), 32'h11);
      rd(); rd(); rd();
      chk("last_rd", 0, 32'(bus0.r_data_o), 32'h44);
      rd();
      chk("udf_extra", 0, 32'(bus0.underflow_o), 32'h1);
      chk("udf_extra", 1, 32'(bus1.underflow_o), 32'h1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("err_clr", 0, 32'({bus0.overflow_o, bus0.underflow_o}), 32'h0);
      chk("err_clr", 1, 32'({bus1.overflow_o, bus1.underflow_o}), 32'h0);

      // FWFT latency: write at t, presented at t+2 without r_en_i
      wr(8'hA5);
      chk("fwft_t1_empty", 1, 32'(bus1.r_empty_o), 32'h1);
      idle();
      chk("fwft_t2_empty", 1, 32'(bus1.r_empty_o), 32'h0);
      chk("fwft_t2_data",  1, 32'(bus1.r_data_o),  32'hA5);
      rd();

      // Fill 4, hold r_en_i for 4 cycles
      wr(8'h61); wr(8'h62); wr(8'h63); wr(8'h64);
      idle(); idle();
      rd(); rd(); rd(); rd();
      chk("drained_empty", 0, 32'(bus0.r_empty_o), 32'h1);
      chk("drained_empty", 1, 32'(bus1.r_empty_o), 32'h1);

      // Level 3, simultaneous write and read, pointers wrap
      wr(8'h71); wr(8'h72); wr(8'h73); idle();
      step(1'b0, 1'b1, 8'h74, 1'b1, 1'b0, 1'b0);
      chk("wr_rd_level", 0, 32'(bus0.level_o), 32'h3);
      chk("wr_rd_level", 1, 32'(bus1.level_o), 32'h3);
      chk("wr_rd_afull", 1, 32'(bus1.almost_full_o), 32'h1);
      idle(); rd(); rd(); rd(); idle();

      // Flush with a write pending keeps the sticky overflow
      wr(8'h81); wr(8'h82); wr(8'h83); wr(8'h84); wr(8'h85);
      idle(); rd(); rd();
      step(1'b0, 1'b1, 8'h86, 1'b0, 1'b1, 1'b0);
      chk("flush_level", 0, 32'(bus0.level_o), 32'h0);
      chk("flush_level", 1, 32'(bus1.level_o), 32'h0);
      chk("flush_empty", 1, 32'(bus1.r_empty_o), 32'h1);
      chk("flush_ovf",   0, 32'(bus0.overflow_o), 32'h1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("clr_ovf", 1, 32'(bus1.overflow_o), 32'h0);

      // Reset in the middle of traffic
      wr(8'h91); wr(8'h92);
      step(1'b1, 1'b1, 8'h93, 1'b1, 1'b0, 1'b0);
      chk("midrst_level", 1, 32'(bus1.level_o), 32'h0);
      idle();

      // Random traffic: write-heavy first half, read-heavy second half
      for (int n = 0; n < 800; n++) begin
         int wp;
         wp = (n < 400) ? 70 : 35;
         step(($urandom_range(99) < 1),
              ($urandom_range(99) < wp),
              DW'($urandom_range(255)),
              ($urandom_range(99) < (100 - wp)),
              ($urandom_range(99) < 3),
              ($urandom_range(99) < 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_iob_fifo_sync_fwft
